// File: rtl/counter_arbiter_if.sv
// Request/grant bundle between the stimulus engines and the shared interval counter.
interface counter_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] delay;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   aborted;
  logic                   busy;
  logic [WIDTH-1:0]       count;
  logic [ID_W-1:0]        active_id;

  // Requester side: drives requests and delays, observes the arbiter.
  modport master (
    output req, delay,
    input  grant, done, aborted, busy, count, active_id
  );

  // Arbiter side: samples requests, drives grant and interval status.
  modport slave (
    input  req, delay,
    output grant, done, aborted, busy, count, active_id
  );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin shared interval counter: one requester at a time owns a
// prescaled up-counter that runs for the delay latched at grant time.
module counter_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  counter_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int CW   = ID_W + 1;  // wide enough for last+1+k before wrapping
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [ID_W-1:0] LAST_RST   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]  dlat_q, dlat_d;

  // Per-requester views of the flattened delay bus and of the winner.
  logic [WIDTH-1:0]  delay_arr [N_REQ];
  logic [N_REQ-1:0]  win_onehot;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [CW-1:0]     cand;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign delay_arr[gi]  = bus.delay[gi*WIDTH +: WIDTH];
    assign win_onehot[gi] = win_found && (win_id == ID_W'(gi));
  end

  // Round-robin pick: first requesting index scanning upward from last+1 with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, last_q} + CW'(k + 1);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!win_found && bus.req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; done/aborted are single-cycle pulses.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    aborted_d   = 1'b0;
    busy_d      = busy_q;
    count_d     = count_q;
    presc_d     = presc_q;
    active_id_d = active_id_q;
    last_d      = last_q;
    dlat_d      = dlat_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        presc_d = '0;
        if (win_found) begin
          grant_d     = win_onehot;
          active_id_d = win_id;
          last_d      = win_id;
          dlat_d      = delay_arr[win_id];
          busy_d      = 1'b1;
          if (delay_arr[win_id] == '0) begin
            // Zero-length interval: skip RUN, report completion right away.
            state_d = DONE;
            done_d  = win_onehot;
          end else begin
            // count shows the tick in progress, so the first RUN cycle reads 1.
            state_d = RUN;
            count_d = WIDTH'(1);
          end
        end
      end

      RUN: begin
        if (!bus.req[active_id_q]) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          grant_d   = '0;
          busy_d    = 1'b0;
          count_d   = '0;
          presc_d   = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (count_q == dlat_q) begin
            state_d = DONE;
            done_d  = grant_q;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      DONE: begin
        // req is ignored here; the owner is released unconditionally.
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        presc_d = '0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        presc_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any interval without a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      presc_q     <= '0;
      active_id_q <= '0;
      last_q      <= LAST_RST;
      dlat_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      active_id_q <= active_id_d;
      last_q      <= last_d;
      dlat_q      <= dlat_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.active_id = active_id_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: one PRESCALE=1 instance and one PRESCALE=4 instance.
module tb_counter_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  counter_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_a ();
  counter_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_b ();

  counter_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE(1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  counter_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Safety net in case the directed sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] exp_g;
    int rr_order [5] = '{0, 1, 2, 3, 0};

    reset       = 1'b1;
    bus_a.req   = '0;
    bus_a.delay = '0;
    bus_b.req   = '0;
    bus_b.delay = '0;
    step(); step(); step();

    // Reset values
    chk("rst_grant", 32'(bus_a.grant), 32'h0);
    chk("rst_done", 32'(bus_a.done), 32'h0);
    chk("rst_aborted", 32'(bus_a.aborted), 32'h0);
    chk("rst_busy", 32'(bus_a.busy), 32'h0);
    chk("rst_count", 32'(bus_a.count), 32'h0);
    chk("rst_active_id", 32'(bus_a.active_id), 32'h0);
    chk("rst_b_grant", 32'(bus_b.grant), 32'h0);
    reset = 1'b0;
    step();
    $display("reset released, outputs idle");

    // Single request on requester 2, delay 5
    bus_a.req = 4'b0100;
    bus_a.delay[2*W +: W] = 16'd5;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("single_grant_c%0d", k), 32'(bus_a.grant), 32'h4);
      chk($sformatf("single_count_c%0d", k), 32'(bus_a.count), 32'(k));
      chk($sformatf("single_done_c%0d", k), 32'(bus_a.done), 32'h0);
      chk($sformatf("single_busy_c%0d", k), 32'(bus_a.busy), 32'h1);
    end
    chk("single_active_id", 32'(bus_a.active_id), 32'h2);
    step();
    chk("single_done_pulse", 32'(bus_a.done), 32'h4);
    chk("single_done_grant", 32'(bus_a.grant), 32'h4);
    chk("single_done_count", 32'(bus_a.count), 32'h5);
    bus_a.req = '0;
    step();
    chk("single_idle_grant", 32'(bus_a.grant), 32'h0);
    chk("single_idle_count", 32'(bus_a.count), 32'h0);
    chk("single_idle_done", 32'(bus_a.done), 32'h0);
    chk("single_idle_busy", 32'(bus_a.busy), 32'h0);
    $display("single request: grant=%b done seen, back to idle", 4'b0100);

    // Zero delay on requester 0: grant and done together
    bus_a.req = 4'b0001;
    bus_a.delay[0 +: W] = 16'd0;
    step();
    chk("zero_grant", 32'(bus_a.grant), 32'h1);
    chk("zero_done", 32'(bus_a.done), 32'h1);
    chk("zero_busy", 32'(bus_a.busy), 32'h1);
    chk("zero_count", 32'(bus_a.count), 32'h0);
    bus_a.req = '0;
    step();
    chk("zero_idle_grant", 32'(bus_a.grant), 32'h0);
    chk("zero_idle_done", 32'(bus_a.done), 32'h0);
    chk("zero_idle_busy", 32'(bus_a.busy), 32'h0);
    $display("zero delay: grant and done in same cycle");

    // Abort: requester 3 drops req mid-interval, requester 0 waiting
    bus_a.req = 4'b1000;
    bus_a.delay[3*W +: W] = 16'd10;
    bus_a.delay[0 +: W]   = 16'd2;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("abort_grant_c%0d", k), 32'(bus_a.grant), 32'h8);
      chk($sformatf("abort_count_c%0d", k), 32'(bus_a.count), 32'(k));
    end
    bus_a.req = 4'b0001;
    step();
    chk("abort_pulse", 32'(bus_a.aborted), 32'h1);
    chk("abort_grant_zero", 32'(bus_a.grant), 32'h0);
    chk("abort_no_done", 32'(bus_a.done), 32'h0);
    chk("abort_busy", 32'(bus_a.busy), 32'h0);
    step();
    chk("abort_next_grant", 32'(bus_a.grant), 32'h1);
    chk("abort_next_id", 32'(bus_a.active_id), 32'h0);
    chk("abort_pulse_gone", 32'(bus_a.aborted), 32'h0);
    bus_a.req = '0;
    step();
    chk("abort2_pulse", 32'(bus_a.aborted), 32'h1);
    step();
    $display("abort: aborted pulse with grant=0, pending req0 granted next");

    // Reset in the middle of RUN
    bus_a.req = 4'b0010;
    bus_a.delay[1*W +: W] = 16'd20;
    step();
    chk("rstrun_grant", 32'(bus_a.grant), 32'h2);
    step();
    chk("rstrun_count", 32'(bus_a.count), 32'h2);
    reset     = 1'b1;
    bus_a.req = 4'b0011;
    bus_a.delay[0 +: W] = 16'd3;
    step();
    chk("rstrun_grant_zero", 32'(bus_a.grant), 32'h0);
    chk("rstrun_no_done", 32'(bus_a.done), 32'h0);
    chk("rstrun_no_abort", 32'(bus_a.aborted), 32'h0);
    chk("rstrun_busy", 32'(bus_a.busy), 32'h0);
    chk("rstrun_count_zero", 32'(bus_a.count), 32'h0);
    chk("rstrun_id_zero", 32'(bus_a.active_id), 32'h0);
    reset = 1'b0;
    step();
    chk("rstrun_first_grant", 32'(bus_a.grant), 32'h1);
    bus_a.req = '0;
    step();
    step();
    $display("reset mid-run: outputs cleared, req0 wins after reset");

    // Round-robin fairness with every requester asking for 2 ticks
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) bus_a.delay[i*W +: W] = 16'd2;
    bus_a.req = 4'b1111;
    foreach (rr_order[j]) begin
      exp_g = 4'b0001 << rr_order[j];
      for (int c = 0; c < 3; c++) begin
        step();
        chk($sformatf("rr%0d_grant_c%0d", j, c), 32'(bus_a.grant), 32'(exp_g));
        if (c == 2) begin
          chk($sformatf("rr%0d_done", j), 32'(bus_a.done), 32'(exp_g));
          chk($sformatf("rr%0d_count", j), 32'(bus_a.count), 32'h2);
          if (j == 4) bus_a.req = '0;
        end
      end
      step();
      chk($sformatf("rr%0d_gap", j), 32'(bus_a.grant), 32'h0);
      $display("round robin: grant to requester %0d", rr_order[j]);
    end
    step();
    chk("rr_final_idle", 32'(bus_a.grant), 32'h0);

    // Prescaler of 4 on the second instance, requester 1 delay 3
    bus_b.req = 4'b0010;
    bus_b.delay[1*W +: W] = 16'd3;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("presc_grant_c%0d", k), 32'(bus_b.grant), 32'h2);
      chk($sformatf("presc_count_c%0d", k), 32'(bus_b.count), 32'((k - 1) / 4 + 1));
      chk($sformatf("presc_done_c%0d", k), 32'(bus_b.done), 32'h0);
    end
    step();
    chk("presc_done_pulse", 32'(bus_b.done), 32'h2);
    chk("presc_done_count", 32'(bus_b.count), 32'h3);
    bus_b.req = '0;
    step();
    chk("presc_idle_grant", 32'(bus_b.grant), 32'h0);
    chk("presc_idle_count", 32'(bus_b.count), 32'h0);
    $display("prescaler: done after 12 run cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
